// File: rtl/montgomery_modexp.sv
// Constant-time modular exponentiation controller: result = base^exp mod (2^64-15),
// sequencing an external Montgomery multiplier through conversion, square-and-multiply and back-conversion.
module montgomery_modexp #(
    parameter int unsigned EXP_W     = 64,
    parameter int unsigned FLUSH_CYC = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      base,
    input  logic [EXP_W-1:0] exp,
    input  logic             taken,
    output logic             ready_in,
    output logic [63:0]      result,
    output logic             ready_out,
    input  logic             given,
    output logic [63:0]      mul_a_bar,
    output logic [63:0]      mul_b_bar,
    output logic             mul_taken,
    input  logic             mul_ready_in,
    input  logic [63:0]      mul_out_bar,
    input  logic             mul_ready_out,
    output logic             mul_given
);

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned BIT_W   = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam int unsigned FLUSH_W = $clog2(FLUSH_CYC + 1);

    // Montgomery domain constants for R = 2^64, N = 2^64 - 15
    localparam logic [DATA_W-1:0] ONE_BAR  = 64'hF;
    localparam logic [DATA_W-1:0] R2_MOD_N = 64'hE1;
    localparam logic [DATA_W-1:0] ONE      = 64'd1;

    typedef enum logic [2:0] {
        S_FLUSH,
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_CONV_IN,
        OP_SQR,
        OP_MULB,
        OP_CONV_OUT
    } op_t;

    state_t             state_q, state_d;
    op_t                op_q, op_d;
    logic [FLUSH_W-1:0] flush_q, flush_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0]  base_bar_q, base_bar_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic [DATA_W-1:0]  result_q, result_d;

    logic               start_job;
    logic               ready_in_c;
    logic               mul_taken_c;
    logic               mul_given_c;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FLUSH;
            op_q       <= OP_CONV_IN;
            flush_q    <= '0;
            bit_q      <= '0;
            exp_q      <= '0;
            acc_q      <= '0;
            base_bar_q <= '0;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            flush_q    <= flush_d;
            bit_q      <= bit_d;
            exp_q      <= exp_d;
            acc_q      <= acc_d;
            base_bar_q <= base_bar_d;
            a_q        <= a_d;
            b_q        <= b_d;
            result_q   <= result_d;
        end
    end

    // Next-state, operand sequencing and handshake decode
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        flush_d     = flush_q;
        bit_d       = bit_q;
        exp_d       = exp_q;
        acc_d       = acc_q;
        base_bar_d  = base_bar_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        start_job   = 1'b0;
        ready_in_c  = 1'b0;
        mul_taken_c = 1'b0;
        mul_given_c = 1'b0;

        case (state_q)
            S_FLUSH: begin
                mul_given_c = mul_ready_out;
                if (flush_q == FLUSH_W'(FLUSH_CYC - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    flush_d = flush_q + FLUSH_W'(1);
                end
            end

            S_IDLE: begin
                ready_in_c  = 1'b1;
                mul_given_c = mul_ready_out;
                start_job   = taken;
            end

            S_ISSUE: begin
                mul_taken_c = mul_ready_in;
                if (mul_ready_in) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                mul_given_c = mul_ready_out;
                if (mul_ready_out) begin
                    state_d = S_ISSUE;
                    case (op_q)
                        OP_CONV_IN: begin
                            base_bar_d = mul_out_bar;
                            op_d       = OP_SQR;
                            a_d        = acc_q;
                            b_d        = acc_q;
                        end
                        OP_SQR: begin
                            acc_d = mul_out_bar;
                            op_d  = OP_MULB;
                            a_d   = mul_out_bar;
                            // The multiply always runs; a clear bit multiplies by one
                            b_d   = exp_q[bit_q] ? base_bar_q : ONE_BAR;
                        end
                        OP_MULB: begin
                            acc_d = mul_out_bar;
                            a_d   = mul_out_bar;
                            if (bit_q == '0) begin
                                op_d = OP_CONV_OUT;
                                b_d  = ONE;
                            end else begin
                                op_d  = OP_SQR;
                                bit_d = bit_q - BIT_W'(1);
                                b_d   = mul_out_bar;
                            end
                        end
                        default: begin
                            result_d = mul_out_bar;
                            state_d  = S_DONE;
                        end
                    endcase
                end
            end

            S_DONE: begin
                ready_in_c = given;
                if (given) begin
                    state_d   = S_IDLE;
                    start_job = taken;
                end
            end

            default: begin
                state_d = S_FLUSH;
                flush_d = '0;
            end
        endcase

        // Job launch shared by IDLE and the DONE hand-over cycle
        if (start_job) begin
            state_d = S_ISSUE;
            op_d    = OP_CONV_IN;
            exp_d   = exp;
            acc_d   = ONE_BAR;
            bit_d   = BIT_W'(EXP_W - 1);
            a_d     = base;
            b_d     = R2_MOD_N;
        end
    end

    assign ready_in  = ready_in_c  & ~rst;
    assign mul_taken = mul_taken_c & ~rst;
    assign mul_given = mul_given_c & ~rst;
    assign ready_out = (state_q == S_DONE);
    assign result    = result_q;
    assign mul_a_bar = a_q;
    assign mul_b_bar = b_q;

endmodule

// File: tb/tb_montgomery_modexp.sv
// Bench for montgomery_modexp: behavioural Montgomery multiplier partner, reference modexp model,
// vector table plus reset, hand-over, mid-job reset and backpressure sequences.
module tb_montgomery_modexp;

    localparam int unsigned EXP_W     = 8;
    localparam int unsigned FLUSH_CYC = 8;
    localparam logic [63:0] N         = 64'hFFFFFFFFFFFFFFF1;
    localparam int          JOB_LAT   = 91;
    localparam int          BOUND     = 3000;

    logic             clk;
    logic             rst;
    logic [63:0]      base_s;
    logic [EXP_W-1:0] exp_s;
    logic             taken;
    logic             ready_in;
    logic [63:0]      result;
    logic             ready_out;
    logic             given;
    logic [63:0]      mul_a_bar;
    logic [63:0]      mul_b_bar;
    logic             mul_taken;
    logic             mul_ready_in;
    logic [63:0]      mul_out_bar;
    logic             mul_ready_out;
    logic             mul_given;

    montgomery_modexp #(
        .EXP_W    (EXP_W),
        .FLUSH_CYC(FLUSH_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .base         (base_s),
        .exp          (exp_s),
        .taken        (taken),
        .ready_in     (ready_in),
        .result       (result),
        .ready_out    (ready_out),
        .given        (given),
        .mul_a_bar    (mul_a_bar),
        .mul_b_bar    (mul_b_bar),
        .mul_taken    (mul_taken),
        .mul_ready_in (mul_ready_in),
        .mul_out_bar  (mul_out_bar),
        .mul_ready_out(mul_ready_out),
        .mul_given    (mul_given)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // a*b*2^-64 mod N, bit-serial REDC
    function automatic logic [63:0] mont_mul(input logic [63:0] a, input logic [63:0] b);
        logic [129:0] t;
        t = 130'(a) * 130'(b);
        for (int i = 0; i < 64; i++) begin
            if (t[0]) t = t + 130'(N);
            t = t >> 1;
        end
        for (int i = 0; i < 3; i++) begin
            if (t >= 130'(N)) t = t - 130'(N);
        end
        return t[63:0];
    endfunction

    function automatic logic [63:0] mulmod(input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        p = 128'(a) * 128'(b);
        p = p % 128'(N);
        return p[63:0];
    endfunction

    function automatic logic [63:0] modexp_ref(input logic [63:0] b, input logic [EXP_W-1:0] e);
        logic [63:0] r;
        logic [63:0] x;
        x = mulmod(b, 64'd1);
        r = 64'd1;
        for (int i = EXP_W - 1; i >= 0; i--) begin
            r = mulmod(r, r);
            if (e[i]) r = mulmod(r, x);
        end
        return r;
    endfunction

    // Multiplier partner: latency 4 taken->ready_out, optional random stalls and extra delay
    logic        rand_mode = 1'b0;
    logic        stub_busy = 1'b0;
    logic        stub_stall = 1'b0;
    int          stub_cnt = 0;
    logic [63:0] stub_res = 64'd0;

    assign mul_ready_in  = !stub_busy && !stub_stall;
    assign mul_ready_out = stub_busy && (stub_cnt == 0);
    assign mul_out_bar   = stub_res;

    always @(posedge clk) begin
        if (mul_given && mul_ready_out) begin
            stub_busy <= 1'b0;
        end else if (stub_busy && stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
        end
        if (mul_taken && mul_ready_in) begin
            stub_busy <= 1'b1;
            stub_cnt  <= 3 + (rand_mode ? int'($urandom_range(0, 6)) : 0);
            stub_res  <= mont_mul(mul_a_bar, mul_b_bar);
        end
        stub_stall <= rand_mode ? ($urandom_range(0, 2) == 0) : 1'b0;
    end

    int taken_cnt = 0;
    int given_cnt = 0;
    int rst_taken_cnt = 0;

    always @(posedge clk) begin
        if (mul_taken && mul_ready_in) taken_cnt <= taken_cnt + 1;
        if (mul_given && mul_ready_out) given_cnt <= given_cnt + 1;
        if (rst && mul_taken) rst_taken_cnt <= rst_taken_cnt + 1;
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] sb[$];

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Entered and left just after a negedge; taken is accepted on the next posedge
    task automatic start_job(input string name, input logic [63:0] b, input logic [EXP_W-1:0] e);
        int cyc;
        cyc = 0;
        while (!ready_in && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
        end
        if (!ready_in) check_int({name, " ready_in timeout"}, 0, 1);
        base_s = b;
        exp_s  = e;
        taken  = 1'b1;
        sb.push_back(modexp_ref(b, e));
        @(negedge clk);
        taken  = 1'b0;
    endtask

    task automatic wait_done(input string name, input bit chk_lat, output logic [63:0] req);
        int lat;
        lat = 1;
        while (!ready_out && lat < BOUND) begin
            @(negedge clk);
            lat++;
        end
        if (!ready_out) check_int({name, " ready_out timeout"}, 0, 1);
        req = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD;
        check64({name, " result"}, result, req);
        if (chk_lat) check_int({name, " latency"}, lat, JOB_LAT);
    endtask

    task automatic host_give();
        given = 1'b1;
        @(negedge clk);
        given = 1'b0;
    endtask

    task automatic wait_flush(input string name);
        int cyc;
        cyc = 0;
        while (!ready_in && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check_int({name, " flush cycles"}, cyc, int'(FLUSH_CYC));
    endtask

    typedef struct {
        logic [63:0]      b;
        logic [EXP_W-1:0] e;
        logic [63:0]      res;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [63:0] req;
        int          t0;
        int          g0;

        vecs[0] = '{64'd3, 8'd5, 64'd243};
        vecs[1] = '{64'd2, 8'd0, 64'd1};
        vecs[2] = '{64'hFFFFFFFFFFFFFFF0, 8'd2, 64'd1};
        vecs[3] = '{64'hFFFFFFFFFFFFFFF1, 8'd3, 64'd0};
        vecs[4] = '{64'hFFFFFFFFFFFFFFFF, 8'd2, 64'd196};
        vecs[5] = '{64'd0, 8'd7, 64'd0};

        rst    = 1'b1;
        taken  = 1'b0;
        given  = 1'b0;
        base_s = '0;
        exp_s  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_int("reset ready_in", int'(ready_in), 0);
        check_int("reset ready_out", int'(ready_out), 0);
        check64("reset result", result, 64'd0);
        check64("reset mul_a_bar", mul_a_bar, 64'd0);
        check64("reset mul_b_bar", mul_b_bar, 64'd0);
        t0  = taken_cnt;
        rst = 1'b0;
        wait_flush("power-on");
        check_int("power-on mul_taken", taken_cnt - t0, 0);

        // Table: constant-time latency and arithmetic corner cases
        foreach (vecs[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            start_job(nm, vecs[i].b, vecs[i].e);
            wait_done(nm, 1'b1, req);
            check64({nm, " table"}, result, vecs[i].res);
            host_give();
        end

        // Result held while the host stalls, then hand-over with a new job in the same cycle
        start_job("hold", 64'd5, 8'd3);
        wait_done("hold", 1'b1, req);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check64("hold result stable", result, 64'd125);
            check_int("hold ready_in low", int'(ready_in), 0);
            check_int("hold ready_out high", int'(ready_out), 1);
        end
        base_s = 64'd6;
        exp_s  = 8'd2;
        given  = 1'b1;
        taken  = 1'b1;
        sb.push_back(modexp_ref(64'd6, 8'd2));
        #1;
        check_int("handover ready_in", int'(ready_in), 1);
        @(negedge clk);
        given = 1'b0;
        taken = 1'b0;
        check_int("handover ready_out drop", int'(ready_out), 0);
        wait_done("handover", 1'b1, req);
        check64("handover 6^2", result, 64'd36);
        host_give();

        // Reset 40 cycles into a job: outputs clear, stale multiplier result flushed
        start_job("midrst", 64'd9, 8'hC5);
        repeat (39) @(negedge clk);
        t0  = taken_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_back());
        check_int("midrst ready_out", int'(ready_out), 0);
        check64("midrst result", result, 64'd0);
        check_int("midrst ready_in", int'(ready_in), 0);
        wait_flush("midrst");
        check_int("midrst mul_taken in flush", taken_cnt - t0, 0);
        start_job("post-rst", 64'd7, 8'd3);
        wait_done("post-rst", 1'b1, req);
        check64("post-rst 7^3", result, 64'd343);
        host_give();

        // Backpressure and variable multiplier latency
        rand_mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            string nm;
            nm = $sformatf("rand%0d", i);
            t0 = taken_cnt;
            g0 = given_cnt;
            start_job(nm, {$urandom, $urandom}, EXP_W'($urandom_range(0, 255)));
            wait_done(nm, 1'b0, req);
            host_give();
            check_int({nm, " mul_taken pulses"}, taken_cnt - t0, 2 * int'(EXP_W) + 2);
            check_int({nm, " mul_given pulses"}, given_cnt - g0, 2 * int'(EXP_W) + 2);
        end
        rand_mode = 1'b0;
        repeat (12) @(negedge clk);

        check_int("mul_taken during rst", rst_taken_cnt, 0);
        check_int("scoreboard drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
